// File: rtl/wb_arb_pkg.sv
// Shared constants, request type and index helper for writeback-port arbitration.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_arb_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // Wrap an index into the range 0..n-1; used for rotate-priority scanning.
   function automatic int rr_wrap(input int idx, input int n);
      return idx % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests from ptr upward and grants the first one set.
// Latency: grant is combinational; ptr updates on the clock edge after a grant.
// Backpressure: advance=0 suppresses every grant and freezes ptr.
module rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [PTR_W-1:0] scan_idx;
   logic             found;

   // Rotate-priority scan: the first set request at or after ptr wins; ptr moves past the winner.
   always_comb begin
      gnt      = '0;
      found    = 1'b0;
      ptr_nxt  = ptr;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = PTR_W'(rr_wrap(int'(ptr) + k, NREQ));
         if (advance && !found && req[scan_idx]) begin
            gnt[scan_idx] = 1'b1;
            found         = 1'b1;
            ptr_nxt       = PTR_W'(rr_wrap(int'(scan_idx) + 1, NREQ));
         end
      end
   end

   // Priority pointer register; unchanged when nothing is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters, round-robin per cycle.
// Latency: a transfer in cycle t drives wr_en/wr_addr/wr_data/wr_dec during cycle t+1.
// Backpressure: req_ready is combinational and held low during hold or reset; no internal queue.
module wb_port_arbiter #(
   parameter int NREQ     = 2,
   parameter int DATA_W   = wb_arb_pkg::DATA_W,
   parameter int ADDR_W   = wb_arb_pkg::ADDR_W,
   parameter int ZERO_REG = wb_arb_pkg::ZERO_REG
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hold,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]      wr_data,
   output logic [2**ADDR_W-1:0]   wr_dec
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NREQ-1:0]   gnt;
   logic              advance;
   logic              xfer;
   logic              keep;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Grants are only issued when the pipeline is neither stalled nor in reset.
   assign advance = !reset && !hold;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (advance),
      .gnt     (gnt)
   );

   assign req_ready = gnt;

   // Steer the granted requester's address and data; grant is one-hot so an OR-mux suffices.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
            sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A granted write to the zero register is consumed but never reaches the bank.
   assign xfer = |gnt;
   assign keep = xfer && (sel_addr != ADDR_W'(ZERO_REG));

   // Output register stage; addr/data hold their last value when no write is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_dec  <= '0;
      end else begin
         wr_en  <= keep;
         wr_dec <= keep ? (NUM_REGS'(1) << sel_addr) : '0;
         if (keep) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with two requesters and a bank model.
// Latency: checks registered outputs one cycle after each handshake.
// Backpressure: exercises hold, reset and contention on the combinational ready.
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   logic          clk;
   logic          reset;
   logic          hold;
   logic [1:0]    req_valid;
   logic [9:0]    req_addr;
   logic [127:0]  req_data;
   logic [1:0]    req_ready;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [63:0]   wr_data;
   logic [31:0]   wr_dec;

   wb_req_t r0;
   wb_req_t r1;

   logic [63:0] bank [NUM_REGS];
   logic        bank_clr;

   int checks;
   int errors;

   assign req_valid = {r1.valid, r0.valid};
   assign req_addr  = {r1.addr, r0.addr};
   assign req_data  = {r1.data, r0.data};

   wb_port_arbiter #(
      .NREQ     (2),
      .DATA_W   (64),
      .ADDR_W   (5),
      .ZERO_REG (31)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_dec    (wr_dec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register bank: captures the strobed write at the end of the cycle it is presented.
   always @(posedge clk) begin
      if (bank_clr) begin
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
      end else if (wr_en) begin
         bank[wr_addr] <= wr_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hold  = 1'b0;
      r0 = '{valid: 1'b1, addr: 5'd3, data: 64'h1};
      r1 = '{valid: 1'b1, addr: 5'd7, data: 64'h2};
      for (int c = 0; c < 3; c++) begin
         step();
         bank_clr = 1'b0;
         checks++;
         if (req_ready !== 2'b00) begin
            errors++; $display("FAIL rst_ready cyc %0d got %b exp 00", c, req_ready);
         end
         checks++;
         if (wr_en !== 1'b0) begin
            errors++; $display("FAIL rst_wr_en cyc %0d got %b exp 0", c, wr_en);
         end
         checks++;
         if (wr_dec !== 32'h0) begin
            errors++; $display("FAIL rst_wr_dec cyc %0d got %h exp 0", c, wr_dec);
         end
      end
      checks++;
      if (wr_addr !== 5'd0 || wr_data !== 64'h0) begin
         errors++; $display("FAIL rst_addr_data got %0d/%h exp 0/0", wr_addr, wr_data);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL rst_release_ptr0 got %b exp 01", req_ready);
      end
      r0.valid = 1'b0;
      r1.valid = 1'b0;
   endtask

   task automatic test_contention();
      logic [1:0]  exp_rdy;
      logic [4:0]  exp_addr;
      logic [63:0] exp_data;
      r0 = '{valid: 1'b1, addr: 5'd3, data: 64'hAAAA};
      r1 = '{valid: 1'b1, addr: 5'd7, data: 64'h5555};
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 5'd3 : 5'd7;
         exp_data = (k % 2 == 0) ? 64'hAAAA : 64'h5555;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL cont_ready k%0d got %b exp %b", k, req_ready, exp_rdy);
         end
         step();
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== exp_addr || wr_data !== exp_data) begin
            errors++; $display("FAIL cont_write k%0d got %b/%0d/%h exp 1/%0d/%h",
                               k, wr_en, wr_addr, wr_data, exp_addr, exp_data);
         end
         checks++;
         if (wr_dec !== (32'h1 << exp_addr)) begin
            errors++; $display("FAIL cont_dec k%0d got %h exp %h", k, wr_dec, 32'h1 << exp_addr);
         end
      end
      r0.valid = 1'b0;
      r1.valid = 1'b0;
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_dec !== 32'h0) begin
         errors++; $display("FAIL cont_idle got %b/%h exp 0/0", wr_en, wr_dec);
      end
   endtask

   task automatic test_zero_reg();
      r0 = '{valid: 1'b1, addr: 5'd31, data: 64'hDEAD};
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL zero_ready got %b exp 01", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_dec !== 32'h0) begin
         errors++; $display("FAIL zero_drop got %b/%h exp 0/0", wr_en, wr_dec);
      end
      checks++;
      if (wr_addr !== 5'd7 || wr_data !== 64'h5555) begin
         errors++; $display("FAIL zero_hold got %0d/%h exp 7/5555", wr_addr, wr_data);
      end
      r0.valid = 1'b0;
      r1 = '{valid: 1'b1, addr: 5'd2, data: 64'h2222};
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL zero_next_ready got %b exp 10", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd2 || wr_dec !== 32'h4) begin
         errors++; $display("FAIL zero_next_write got %b/%0d/%h exp 1/2/4", wr_en, wr_addr, wr_dec);
      end
      r1.valid = 1'b0;
      step();
      checks++;
      if (bank[31] !== 64'h0 || bank[2] !== 64'h2222) begin
         errors++; $display("FAIL zero_bank got r31=%h r2=%h exp 0/2222", bank[31], bank[2]);
      end
   endtask

   task automatic test_hold();
      r0 = '{valid: 1'b1, addr: 5'd4, data: 64'h4444};
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL hold_pre_ready got %b exp 01", req_ready);
      end
      step();
      r0.valid = 1'b0;
      r1 = '{valid: 1'b1, addr: 5'd6, data: 64'h6666};
      hold = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
         errors++; $display("FAIL hold_ready0 got %b exp 00", req_ready);
      end
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 64'h4444) begin
         errors++; $display("FAIL hold_inflight got %b/%0d/%h exp 1/4/4444", wr_en, wr_addr, wr_data);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || req_ready !== 2'b00) begin
         errors++; $display("FAIL hold_cyc1 got en=%b rdy=%b exp 0/00", wr_en, req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b0) begin
         errors++; $display("FAIL hold_cyc2 got %b exp 0", wr_en);
      end
      hold = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL hold_release_ready got %b exp 10", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd6 || wr_data !== 64'h6666) begin
         errors++; $display("FAIL hold_release_write got %b/%0d/%h exp 1/6/6666", wr_en, wr_addr, wr_data);
      end
      r1.valid = 1'b0;
   endtask

   task automatic test_same_addr();
      r0 = '{valid: 1'b1, addr: 5'd10, data: 64'h1010};
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL same_setup_ready got %b exp 01", req_ready);
      end
      step();
      r0 = '{valid: 1'b1, addr: 5'd5, data: 64'd1};
      r1 = '{valid: 1'b1, addr: 5'd5, data: 64'd2};
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL same_first_ready got %b exp 10", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'd2) begin
         errors++; $display("FAIL same_first_write got %b/%0d/%0d exp 1/5/2", wr_en, wr_addr, wr_data);
      end
      r1.valid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL same_second_ready got %b exp 01", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 64'd1) begin
         errors++; $display("FAIL same_second_write got %b/%0d exp 1/1", wr_en, wr_data);
      end
      r0.valid = 1'b0;
      step();
      checks++;
      if (bank[5] !== 64'd1 || bank[10] !== 64'h1010) begin
         errors++; $display("FAIL same_bank got r5=%h r10=%h exp 1/1010", bank[5], bank[10]);
      end
   endtask

   task automatic test_reset_mid();
      r0 = '{valid: 1'b1, addr: 5'd9, data: 64'h9999};
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
         errors++; $display("FAIL rmid_ready got %b exp 00", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_dec !== 32'h0 || wr_addr !== 5'd0) begin
         errors++; $display("FAIL rmid_drop got %b/%h/%0d exp 0/0/0", wr_en, wr_dec, wr_addr);
      end
      reset = 1'b0;
      r0.valid = 1'b0;
      step();
      checks++;
      if (bank[9] !== 64'h0) begin
         errors++; $display("FAIL rmid_bank got %h exp 0", bank[9]);
      end
      r0.valid = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL rmid_represent_ready got %b exp 01", req_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_dec !== 32'h200) begin
         errors++; $display("FAIL rmid_represent_write got %b/%0d/%h exp 1/9/200", wr_en, wr_addr, wr_dec);
      end
      r0.valid = 1'b0;
      step();
      checks++;
      if (bank[9] !== 64'h9999) begin
         errors++; $display("FAIL rmid_bank_after got %h exp 9999", bank[9]);
      end
   endtask

   task automatic test_back_to_back();
      r1 = '{valid: 1'b1, addr: 5'd12, data: 64'h0};
      for (int k = 0; k < 3; k++) begin
         r1.data = 64'(k + 1);
         #1;
         checks++;
         if (req_ready !== 2'b10) begin
            errors++; $display("FAIL b2b_ready k%0d got %b exp 10", k, req_ready);
         end
         step();
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== 5'd12 || wr_data !== 64'(k + 1)) begin
            errors++; $display("FAIL b2b_write k%0d got %b/%0d/%0d exp 1/12/%0d", k, wr_en, wr_addr, wr_data, k + 1);
         end
      end
      r1.valid = 1'b0;
      step();
      checks++;
      if (wr_en !== 1'b0) begin
         errors++; $display("FAIL b2b_idle got %b exp 0", wr_en);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      bank_clr = 1'b1;
      reset    = 1'b1;
      hold     = 1'b0;
      r0       = '0;
      r1       = '0;
      test_reset();
      test_contention();
      test_zero_reg();
      test_hold();
      test_same_addr();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback requesters, e.g. the ALU path and the load path.
- The register file is a bank of 64-bit enabled registers, one per architectural register.
- The block round-robin arbitrates per cycle, registers the winning write, and drives a one-hot per-register enable vector straight into the bank's enable pins.
- Writes to the zero register are accepted and silently dropped.

Parameters:
- NREQ, 2, number of requesters (2..4)
- DATA_W, 64, write data width
- ADDR_W, 5, register index width; bank depth is 2**ADDR_W
- ZERO_REG, 31, index whose writes are discarded

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  pipeline stall; when 1 no grants are issued
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*ADDR_W  destination index; slice i = bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  write data; slice i = bits [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  grant to requester i, combinational, at most one bit set
- wr_en  out  1  registered write strobe
- wr_addr  out  ADDR_W  registered destination index
- wr_data  out  DATA_W  registered write data
- wr_dec  out  2**ADDR_W  registered one-hot enable; all zero when wr_en=0

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: ptr=0, wr_en=0, wr_addr=0, wr_data=0, wr_dec=0.
  - req_ready is 0 whenever reset=1 or hold=1.
- Handshake:
  - A transfer occurs on cycle t when req_valid[i] and req_ready[i] are both 1.
  - Requesters hold valid, addr and data stable until accepted; ready never depends on the requester's own addr or data.
- Arbitration:
  - Round-robin. Candidates are scanned from index ptr upward, mod NREQ; the first valid one wins.
  - After a grant to index g, ptr becomes (g+1) mod NREQ. With no grant, ptr is unchanged.
- Latency:
  - A transfer on cycle t produces wr_en=1 with the captured addr and data during cycle t+1, for exactly one cycle.
  - The bank captures at the end of t+1.
  - Back-to-back transfers give wr_en=1 on consecutive cycles; throughput is 1 write per cycle.
- Zero register:
  - A transfer with addr==ZERO_REG is accepted and advances ptr.
  - In t+1: wr_en=0, wr_dec=0; wr_addr and wr_data hold their previous values.
- wr_dec:
  - bit wr_addr = wr_en; all other bits 0.
  - Exactly one bit is set when wr_en=1.
- Same-address requests:
  - If several requesters target the same index in one cycle, the losers wait.
  - Final register content equals the data of the last-granted writer.
  - No merging, no dropping.
- Hold:
  - hold=1 on cycle t means no grant in t and wr_en=0 in t+1.
  - A write already captured in cycle t-1 still issues in t, so hold does not cancel an in-flight write.
- Reset mid-operation:
  - A write granted in the cycle reset rises is discarded; wr_en=0 in the next cycle.
  - Requesters must re-present it.
- Single requester: a continuously valid requester with no contention is granted every cycle.
- Internal state is limited to ptr, the output registers and combinational grant logic. There is no internal queue.

Decomposition:
- Package wb_arb_pkg holds:
  - constants DATA_W=64, ADDR_W=5, ZERO_REG=31, NUM_REGS=32
  - typedef wb_req_t {logic valid; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}
- Sub-module rr_arbiter(clk, reset, req[NREQ], advance, gnt[NREQ]):
  - owns ptr and the rotate-priority grant logic
  - reused by future shared-port blocks
- Top level contains the output registers and the index-to-one-hot decoder.

Test Plan:
- Reset hold: assert reset 3 cycles with req_valid=2'b11 -> req_ready=0, wr_en=0, wr_dec=0 throughout; ptr=0 after release.
- Contention alternation:
  - stimulus: req0=(addr 3, data 64'hAAAA), req1=(addr 7, data 64'h5555), both held valid 4 cycles
  - grants: cycle0 req0, cycle1 req1, cycle2 req0, cycle3 req1
  - outputs one cycle later: wr_addr 3,7,3,7; wr_dec = 1<<3, 1<<7, ...
- Zero-register drop: req0 addr 31, data 64'hDEAD -> req_ready[0]=1 next cycle; wr_en=0, wr_dec=0; a following req1 addr 2 is still granted.
- Hold:
  - stimulus: hold=1 while req1 valid for 2 cycles -> req_ready=0 and no wr_en except the single pre-hold write issuing in the first hold cycle
  - on release, req1 is granted; wr_en one cycle later
- Same-address ordering:
  - stimulus: ptr=1; req0 and req1 both addr 5, data 1 and 2 respectively
  - required: req1 granted first, wr_data=2; then req0 granted, wr_data=1
  - a bank model holds 1 at register 5
- Reset mid-write: grant req0 addr 9 on cycle t with reset=1 on t -> wr_en=0 at t+1; register 9 unchanged in the bank model.
